// File: rtl/fsm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsm_arb_pkg
// Description : Shared types and helpers for the N-agent round-robin arbiter.
//               Provides the arbiter state enum, the agent-count ceiling and
//               a one-hot to index conversion used by the picker.
// Revision    : 1.0  initial release
// ============================================================================
package fsm_arb_pkg;

  // Upper bound on the number of agents any arbiter instance may serve
  localparam int c_MAX_NUM_REQ = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index of the set bit in a one-hot vector; zero when no bit is set
  function automatic int onehot_to_idx(input logic [c_MAX_NUM_REQ-1:0] i_oh);
    int v_idx;
    v_idx = 0;
    for (int i = 0; i < c_MAX_NUM_REQ; i++) begin
      if (i_oh[i]) begin
        v_idx = v_idx | i;
      end
    end
    return v_idx;
  endfunction

endpackage : fsm_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority picker. Returns the first
//               requesting agent found searching upward from (i_ptr+1) mod
//               NUM_REQ with wrap-around, plus a flag that any request exists.
// Revision    : 1.0  initial release
// ============================================================================
module rr_pick
  import fsm_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W-1:0]          w_start;
  logic [NUM_REQ-1:0]       w_rot;
  logic [c_MAX_NUM_REQ-1:0] w_rot_oh;
  logic                     w_hit;
  int                       w_offset;
  int                       w_winner;

  // Search starts one past the last owner; NUM_REQ need not be a power of two
  assign w_start = (i_ptr == ID_W'(NUM_REQ - 1)) ? '0 : i_ptr + 1'b1;

  // Rotate so bit 0 of w_rot is the highest-priority agent this cycle
  assign w_rot = NUM_REQ'({i_req, i_req} >> w_start);

  // Isolate the lowest set bit of the rotated request vector
  always_comb begin
    w_rot_oh = '0;
    w_hit    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_hit && w_rot[k]) begin
        w_rot_oh[k] = 1'b1;
        w_hit       = 1'b1;
      end
    end
  end

  // Undo the rotation to recover the absolute agent index
  always_comb begin
    w_offset = onehot_to_idx(w_rot_oh);
    w_winner = (int'(w_start) + w_offset) % NUM_REQ;
  end

  assign o_idx = ID_W'(w_winner);
  assign o_any = w_hit;

endmodule : rr_pick
`default_nettype wire

// File: rtl/fsm_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : fsm_arbiter_n
// Description : N-agent arbiter FSM with registered one-hot grants and
//               round-robin fairness. One dead cycle separates owners.
//               Optional hold limit (macro ARB_HOLD_LIMIT_EN) forces an owner
//               to release after MAX_HOLD cycles when others are waiting and
//               pulses o_expire; without the macro o_expire is tied low.
// Revision    : 1.0  initial release
// ============================================================================
module fsm_arbiter_n
  import fsm_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 16,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_gnt_valid,
  output logic [ID_W-1:0]    o_gnt_id,
  output logic               o_expire
);

  // Reject out-of-range configurations at elaboration
  if (NUM_REQ < 2 || NUM_REQ > c_MAX_NUM_REQ || MAX_HOLD < 1) begin : g_param_check
    $error("fsm_arbiter_n: NUM_REQ must be 2..16 and MAX_HOLD >= 1");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic               r_gnt_valid;
  logic               w_gnt_valid_nxt;
  logic [ID_W-1:0]    r_gnt_id;
  logic [ID_W-1:0]    w_gnt_id_nxt;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic               r_expire;
  logic               w_expire_nxt;

  logic [ID_W-1:0]    w_win_idx;
  logic               w_win_any;
  logic               w_own_req;
  logic               w_others;
  logic               w_force_rel;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_idx (w_win_idx),
    .o_any (w_win_any)
  );

  // Owner's own request and whether anyone else is waiting
  assign w_own_req = i_req[r_gnt_id];
  assign w_others  = |(i_req & ~r_gnt);

`ifdef ARB_HOLD_LIMIT_EN
  localparam int c_CNT_W = $clog2(MAX_HOLD + 1);

  logic [c_CNT_W-1:0] r_hold_cnt;

  // Counts granted cycles: 1 on a new grant, saturating at MAX_HOLD, 0 when idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_hold_cnt <= w_win_any ? c_CNT_W'(1) : '0;
    end else if (w_own_req && !w_force_rel) begin
      if (r_hold_cnt != c_CNT_W'(MAX_HOLD)) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end else begin
      r_hold_cnt <= '0;
    end
  end

  assign w_force_rel = (r_state == GRANT) && w_own_req && w_others &&
                       (r_hold_cnt == c_CNT_W'(MAX_HOLD));
`else
  assign w_force_rel = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: grant when anyone asks, release on owner drop or forced release
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_win_any) w_state_nxt = GRANT;
      GRANT:   if (!w_own_req || w_force_rel) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and round-robin pointer
  always_comb begin
    w_gnt_nxt       = r_gnt;
    w_gnt_valid_nxt = r_gnt_valid;
    w_gnt_id_nxt    = r_gnt_id;
    w_ptr_nxt       = r_ptr;
    w_expire_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_win_any) begin
          w_gnt_nxt       = NUM_REQ'(1) << w_win_idx;
          w_gnt_valid_nxt = 1'b1;
          w_gnt_id_nxt    = w_win_idx;
          w_ptr_nxt       = w_win_idx;
        end else begin
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
          w_gnt_id_nxt    = '0;
        end
      end
      GRANT: begin
        if (!w_own_req || w_force_rel) begin
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
          w_gnt_id_nxt    = '0;
          w_expire_nxt    = w_force_rel;
        end
      end
      default: begin
        w_gnt_nxt       = '0;
        w_gnt_valid_nxt = 1'b0;
        w_gnt_id_nxt    = '0;
      end
    endcase
  end

  // Grant, pointer and expire registers; pointer resets so agent 0 wins first
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_expire    <= 1'b0;
    end else begin
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_ptr       <= w_ptr_nxt;
      r_expire    <= w_expire_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt_id    = r_gnt_id;
  assign o_expire    = r_expire;

endmodule : fsm_arbiter_n
`default_nettype wire

// File: tb/tb_fsm_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_arbiter_n
// Description : Self-checking bench for fsm_arbiter_n (NUM_REQ=4, MAX_HOLD=4).
//               Directed scenarios plus randomized requests, compared every
//               cycle against a behavioural owner/pointer model. Model follows
//               ARB_HOLD_LIMIT_EN the same way the design does.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fsm_arbiter_n;

  localparam int c_N        = 4;
  localparam int c_MAX_HOLD = 4;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit c_HOLD_EN  = 1'b1;
`else
  localparam bit c_HOLD_EN  = 1'b0;
`endif

  logic           r_clk;
  logic           r_rst;
  logic [c_N-1:0] r_req;
  logic [c_N-1:0] w_gnt;
  logic           w_gnt_valid;
  logic [1:0]     w_gnt_id;
  logic           w_expire;

  int n_checks;
  int n_pass;

  // Reference model: current owner (-1 = none), last owner, granted-cycle count
  int m_owner;
  int m_last;
  int m_held;
  bit m_exp;

  fsm_arbiter_n #(
    .NUM_REQ  (c_N),
    .MAX_HOLD (c_MAX_HOLD)
  ) u_dut (
    .i_clk       (r_clk),
    .i_rst       (r_rst),
    .i_req       (r_req),
    .o_gnt       (w_gnt),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id),
    .o_expire    (w_expire)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the specified behaviour
  task automatic model_step(input logic [c_N-1:0] req, input logic rst);
    m_exp = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_last  = c_N - 1;
      m_held  = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= c_N; k++) begin
        int j;
        j = (m_last + k) % c_N;
        if (m_owner < 0 && req[j]) begin
          m_owner = j;
          m_last  = j;
          m_held  = 1;
        end
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else if (c_HOLD_EN && m_held >= c_MAX_HOLD &&
                 (req & ~(c_N'(1) << m_owner)) != '0) begin
      m_owner = -1;
      m_exp   = 1'b1;
    end else if (m_held < c_MAX_HOLD) begin
      m_held = m_held + 1;
    end
  endtask

  task automatic tick(input logic [c_N-1:0] req, input logic rst);
    logic [c_N-1:0] e_gnt;
    r_req = req;
    r_rst = rst;
    @(posedge r_clk);
    model_step(req, rst);
    #1;
    e_gnt = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    check("gnt",       32'(w_gnt),       32'(e_gnt));
    check("gnt_valid", 32'(w_gnt_valid), 32'(m_owner >= 0));
    check("gnt_id",    32'(w_gnt_id),    32'((m_owner >= 0) ? m_owner : 0));
    check("expire",    32'(w_expire),    32'(m_exp));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_owner  = -1;
    m_last   = c_N - 1;
    m_held   = 0;
    m_exp    = 1'b0;
    r_req    = '0;
    r_rst    = 1'b1;

    // Reset state
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b1);
    check("reset_gnt", 32'(w_gnt), 32'h0);
    tick(4'b0000, 1'b0);

    // Reset mid-grant, then first arbitration after reset goes to agent 0
    tick(4'b0100, 1'b0);
    check("grant_agent2", 32'(w_gnt), 32'h4);
    tick(4'b0100, 1'b0);
    tick(4'b0100, 1'b1);
    check("reset_midgrant_gnt", 32'(w_gnt), 32'h0);
    check("reset_midgrant_id", 32'(w_gnt_id), 32'h0);
    tick(4'b1111, 1'b0);
    check("after_reset_first", 32'(w_gnt), 32'h1);

    // Round-robin rotation: owner holds 3 cycles then drops for one
    for (int i = 1; i <= 4; i++) begin
      tick(4'b1111, 1'b0);
      tick(4'b1111, 1'b0);
      tick(4'b1111 & ~(4'b0001 << w_gnt_id), 1'b0);
      check("rr_deadcycle", 32'(w_gnt), 32'h0);
      tick(4'b1111, 1'b0);
      check("rr_order", 32'(w_gnt_id), 32'(i % 4));
    end
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);

    // Wrap-around: agent 3 was last owner, 4'b1001 must pick agent 0
    tick(4'b0000, 1'b1);
    tick(4'b1000, 1'b0);
    tick(4'b0000, 1'b0);
    tick(4'b1001, 1'b0);
    check("wrap_to_agent0", 32'(w_gnt), 32'h1);
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);

    // Two-way contention held for 20 cycles (expiry only in hold-limit build)
    tick(4'b0000, 1'b1);
    for (int i = 0; i < 20; i++) tick(4'b0011, 1'b0);
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);

    // Lone requester for 40 cycles never expires
    for (int i = 0; i < 40; i++) tick(4'b0100, 1'b0);
    tick(4'b0000, 1'b0);

    // Randomized requests with rare resets; owners tend to keep requesting
    for (int i = 0; i < 400; i++) begin
      logic [c_N-1:0] v_req;
      logic           v_rst;
      for (int b = 0; b < c_N; b++) v_req[b] = ($urandom_range(0, 99) < 60);
      if (m_owner >= 0 && $urandom_range(0, 99) < 80) v_req[m_owner] = 1'b1;
      v_rst = ($urandom_range(0, 99) < 2);
      tick(v_req, v_rst);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fsm_arbiter_n
`default_nettype wire

// File: doc/fsm_arbiter_n.md
# fsm_arbiter_n

Parametrised N-agent arbiter FSM that grants one requester at a time with registered one-hot grants and round-robin fairness. It also provides an optional hold-limit that forces a long-running owner to release when others are waiting. It sits between N request sources and a shared resource, and is the generalised successor to the fixed 4-agent, fixed-priority grant FSM.

## Interface
- NUM_REQ, 4, number of agents; legal 2..16
- MAX_HOLD, 16, max consecutive grant cycles before forced release (hold-limit build only); legal ≥1
- ID_W, $clog2(NUM_REQ), width of gnt_id (derived, not overridden)
- clock  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  active-high request per agent, level
- gnt  out  NUM_REQ  active-high registered grant, one-hot or zero
- gnt_valid  out  1  high when any gnt bit is high
- gnt_id  out  ID_W  index of granted agent; 0 when gnt_valid=0
- expire  out  1  one-cycle pulse on forced release (0 when hold-limit is compiled out)

## Operation
- States: IDLE, GRANT.
- Reset (sampled high at posedge): state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, expire=0, hold counter=0, rr pointer=NUM_REQ-1. Agent 0 therefore wins the first arbitration. Reset overrides everything, including mid-grant; grant drops at that edge.
- IDLE, req==0: stay IDLE, outputs 0.
- IDLE, req!=0: select the first set bit searching from (ptr+1) mod NUM_REQ upward with wrap. Set gnt one-hot, gnt_id=winner, gnt_valid=1, ptr=winner, counter=1, state→GRANT.
- GRANT, req[gnt_id]==0: clear gnt/gnt_valid/gnt_id, state→IDLE. A new grant is possible at the following edge earliest (mandatory one dead cycle between owners).
- GRANT, req[gnt_id]==1: hold grant; counter increments, saturating at MAX_HOLD.
- Hold-limit: in GRANT with counter==MAX_HOLD, req[gnt_id]==1, and any other req bit set → clear grant, state→IDLE, expire=1 for that cycle. ptr already points at the owner, so the next search starts after it.
- Same case with no other requester → keep holding; counter stays saturated and no expire.
- Requests from non-owners never affect gnt while in GRANT, except through the hold-limit.
- Invariant: popcount(gnt)≤1; gnt_valid == |gnt; gnt_id consistent with gnt.

## Timing
- All outputs are registered; no combinational path from req to any output.
- Grant latency: req set before edge k (state IDLE) → gnt high after edge k.
- Release latency: owner drops req before edge k → gnt low after edge k.
- Handover minimum: 1 cycle of gnt==0 between two different owners.
- Forced release: owner granted at edge k (counter=1) is released at edge k+MAX_HOLD if contention exists then; expire is high for the cycle after that edge.
- Counter width: $clog2(MAX_HOLD+1) bits, unsigned, saturating; never wraps.

## Configuration
- Macro ARB_HOLD_LIMIT_EN.
- Defined: hold counter and forced-release logic are present; expire is driven as above.
- Undefined: no counter is instantiated; an owner holds indefinitely while its req is high; expire is tied to 0; MAX_HOLD is ignored.
- Round-robin, state machine and ports are identical in both builds.

## Structure
- Package fsm_arb_pkg: state enum (IDLE=1'b0, GRANT=1'b1), NUM_REQ upper-bound constant, and function for one-hot→index.
- Sub-module rr_pick: combinational rotating-priority picker (inputs req, ptr; outputs winner index, any). Instantiated once.
- Top: state register, grant/pointer registers, hold counter under ARB_HOLD_LIMIT_EN.

## Test plan
- Reset mid-grant: agent 2 granted, assert reset one cycle → next cycle gnt=0, gnt_id=0, state IDLE; then req=4'b1111 → gnt=4'b0001.
- Round-robin rotation: NUM_REQ=4, req=4'b1111 held, each owner drops req for one cycle after 3 granted cycles then reasserts → grant order 0,1,2,3,0, with exactly one gnt==0 cycle between each.
- Wrap-around: ptr=3 (agent 3 last owner), req=4'b1001 → agent 0 granted.
- Hold-limit expiry (macro defined, MAX_HOLD=4): req=4'b0011 constant → gnt=0001 for 4 cycles, expire pulse, 1 idle cycle, gnt=0010 for 4 cycles, then back to agent 0.
- No contention (macro defined): req=4'b0100 for 40 cycles → gnt=0100 throughout, expire never asserted.
- Macro undefined, MAX_HOLD=4: req=4'b0011 for 20 cycles → agent 0 holds all 20 cycles, expire=0.
